// File: rtl/pulse_train_sched_pkg.sv
// Shared types and default sizing for the pulse-train scheduler.
package pulse_sched_pkg;

    localparam int unsigned N_CH_DEF = 2;
    localparam int unsigned PW_DEF   = 8;
    localparam int unsigned CW_DEF   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Channel index width, kept at least one bit for a single-channel build.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_train_sched_if.sv
// Request/config/status bundle between requesters and the pulse-train scheduler.
interface pulse_train_sched_if #(
    parameter int unsigned N_CH = pulse_sched_pkg::N_CH_DEF,
    parameter int unsigned PW   = pulse_sched_pkg::PW_DEF,
    parameter int unsigned CW   = pulse_sched_pkg::CW_DEF
) ();
    localparam int unsigned CHW = pulse_sched_pkg::ch_w(N_CH);

    logic [N_CH-1:0]    req;
    logic [N_CH*PW-1:0] period;
    logic [N_CH*CW-1:0] count;
    logic               abort;
    logic [N_CH-1:0]    ack;
    logic [N_CH-1:0]    done;
    logic               op_sig;
    logic               busy;
    logic [CHW-1:0]     cur_ch;

    modport master (
        output req, period, count, abort,
        input  ack, done, op_sig, busy, cur_ch
    );

    modport slave (
        input  req, period, count, abort,
        output ack, done, op_sig, busy, cur_ch
    );

endinterface

// File: rtl/pulse_train_sched_period_pulse_gen.sv
// Period counter: after load, strobes o_pulse once every latched-period cycles while enabled.
module period_pulse_gen #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_en,
    input  logic [PW-1:0] i_period,
    output logic          o_pulse,
    output logic          o_wrap
);

    logic [PW-1:0] r_period;
    logic [PW-1:0] r_cnt;
    logic          r_pulse;

    // r_cnt counts down to zero; the registered strobe follows the zero cycle,
    // which places pulses exactly P cycles after load and every P thereafter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else if (i_load) begin
            r_period <= i_period;
            r_cnt    <= i_period - PW'(1);
            r_pulse  <= 1'b0;
        end else if (i_en) begin
            r_pulse <= (r_cnt == '0);
            r_cnt   <= (r_cnt == '0) ? (r_period - PW'(1)) : (r_cnt - PW'(1));
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign o_pulse = r_pulse;
    assign o_wrap  = (r_cnt == '0);

endmodule

// File: rtl/pulse_train_sched.sv
// Round-robin scheduler granting one channel at a time a train of C pulses spaced P cycles apart.
module pulse_train_sched
    import pulse_sched_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF,
    parameter int unsigned PW   = PW_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input logic                clk,
    input logic                rst,
    pulse_train_sched_if.slave bus
);

    localparam int unsigned CHW = ch_w(N_CH);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CHW-1:0]  r_last;
    logic [CHW-1:0]  w_last_nxt;
    logic [CHW-1:0]  r_cur;
    logic [CHW-1:0]  w_cur_nxt;
    logic [CW-1:0]   r_left;
    logic [CW-1:0]   w_left_nxt;
    logic [N_CH-1:0] r_ack;
    logic [N_CH-1:0] w_ack_nxt;
    logic [N_CH-1:0] r_done;
    logic [N_CH-1:0] w_done_nxt;
    logic            r_busy;
    logic            w_busy_nxt;

    logic            w_grant_vld;
    logic [CHW-1:0]  w_grant_ch;
    logic [PW-1:0]   w_sel_p;
    logic [CW-1:0]   w_sel_c;
    logic            w_load;
    logic            w_en;
    logic            w_pulse;
    logic            w_wrap;

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            if (!w_grant_vld && bus.req[(32'(r_last) + i) % N_CH]) begin
                w_grant_vld = 1'b1;
                w_grant_ch  = CHW'((32'(r_last) + i) % N_CH);
            end
        end
    end

    assign w_sel_p = bus.period[32'(w_grant_ch)*PW +: PW];
    assign w_sel_c = bus.count[32'(w_grant_ch)*CW +: CW];

    // The last pulse and done are produced by the same edge; RUN then lingers
    // one cycle with r_left==0 so busy drops in the cycle after done.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cur_nxt   = r_cur;
        w_left_nxt  = r_left;
        w_ack_nxt   = '0;
        w_done_nxt  = '0;
        w_load      = 1'b0;
        w_en        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_load                = 1'b1;
                    w_ack_nxt[w_grant_ch] = 1'b1;
                    w_cur_nxt             = w_grant_ch;
                    w_last_nxt            = w_grant_ch;
                    w_left_nxt            = w_sel_c;
                    if (w_sel_p != '0 && w_sel_c != '0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_done_nxt[w_grant_ch] = 1'b1;
                    end
                end
            end
            RUN: begin
                if (r_left == '0 || bus.abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_en = 1'b1;
                    if (w_wrap) begin
                        w_left_nxt = r_left - CW'(1);
                        if (r_left == CW'(1)) begin
                            w_done_nxt[r_cur] = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= CHW'(N_CH - 1);
            r_cur   <= '0;
            r_left  <= '0;
            r_ack   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cur   <= w_cur_nxt;
            r_left  <= w_left_nxt;
            r_ack   <= w_ack_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    period_pulse_gen #(
        .PW(PW)
    ) u_ppg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_en    (w_en),
        .i_period(w_sel_p),
        .o_pulse (w_pulse),
        .o_wrap  (w_wrap)
    );

    assign bus.ack    = r_ack;
    assign bus.done   = r_done;
    assign bus.op_sig = w_pulse;
    assign bus.busy   = r_busy;
    assign bus.cur_ch = r_cur;

endmodule

// File: tb/tb_pulse_train_sched.sv
// Bench for pulse_train_sched: directed train table, corner sequences, random traffic vs a train-level model.
module tb_pulse_train_sched;
    import pulse_sched_pkg::*;

    localparam int unsigned N_CH = 2;
    localparam int unsigned PW   = 8;
    localparam int unsigned CW   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pulse_train_sched_if #(.N_CH(N_CH), .PW(PW), .CW(CW)) bus ();

    pulse_train_sched #(.N_CH(N_CH), .PW(PW), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input int ch, input int p, input int c);
        bus.period[ch*PW +: PW] = PW'(p);
        bus.count[ch*CW +: CW]  = CW'(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        bus.abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] req;
        int p;
        int c;
        int abort_off;
        int ch;
        int npulse;
        int first;
        int last;
        int done_off;
        int busy_low;
    } vec_t;

    vec_t vt[9];

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        int ch, np, first, last, done_off, busy_low, bound;
        @(negedge clk);
        set_cfg(0, v.p, v.c);
        set_cfg(1, v.p, v.c);
        bus.req = v.req;
        bus.abort = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.ack == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.ack == '0) begin
            chk($sformatf("vec%0d.ack_timeout", idx), 0, 1);
            bus.req = '0;
            return;
        end
        ch = bus.ack[1] ? 1 : 0;
        chk($sformatf("vec%0d.ch", idx), ch, v.ch);
        chk($sformatf("vec%0d.cur_ch", idx), bus.cur_ch, v.ch);
        bus.req = '0;
        np = 0; first = -1; last = -1; done_off = -1; busy_low = -1;
        bound = v.p * v.c + 6;
        for (int off = 0; off <= bound; off++) begin
            if (bus.op_sig) begin
                np++;
                if (first < 0) first = off;
                last = off;
            end
            if (bus.done != '0 && done_off < 0) done_off = off;
            if (!bus.busy && busy_low < 0) busy_low = off;
            bus.abort = (v.abort_off > 0 && off == v.abort_off);
            @(negedge clk);
        end
        bus.abort = 1'b0;
        chk($sformatf("vec%0d.npulse", idx), np, v.npulse);
        chk($sformatf("vec%0d.first", idx), first, v.first);
        chk($sformatf("vec%0d.last", idx), last, v.last);
        chk($sformatf("vec%0d.done_off", idx), done_off, v.done_off);
        chk($sformatf("vec%0d.busy_low", idx), busy_low, v.busy_low);
    endtask

    // Train-level reference: a train granted into cycle t0 pulses at t0+k*P for k=1..C.
    int m_run, m_t0, m_p, m_c, m_ch, m_last, m_cyc;
    logic [N_CH-1:0] e_ack, e_done;
    logic            e_op, e_busy;
    int              e_cur;

    task automatic model_step();
        int k, ch, p, c;
        e_ack = '0; e_done = '0; e_op = 1'b0; e_busy = 1'b0; e_cur = -1;
        if (m_run != 0) begin
            if (m_cyc == m_t0 + m_c * m_p || bus.abort) begin
                m_run = 0;
            end else begin
                k = m_cyc + 1 - m_t0;
                e_busy = 1'b1;
                e_cur  = m_ch;
                e_op   = (k % m_p == 0);
                if (e_op && k == m_c * m_p) e_done[m_ch] = 1'b1;
            end
        end else if (bus.req != '0) begin
            ch = -1;
            for (int i = 1; i <= int'(N_CH); i++) begin
                if (ch < 0 && bus.req[(m_last + i) % N_CH]) ch = (m_last + i) % N_CH;
            end
            p = int'(bus.period[ch*PW +: PW]);
            c = int'(bus.count[ch*CW +: CW]);
            e_ack[ch] = 1'b1;
            e_cur = ch;
            m_last = ch;
            if (p == 0 || c == 0) begin
                e_done[ch] = 1'b1;
            end else begin
                m_run = 1; m_t0 = m_cyc + 1; m_p = p; m_c = c; m_ch = ch;
                e_busy = 1'b1;
            end
        end
        @(negedge clk);
        m_cyc++;
        chk("rnd.ack", bus.ack, e_ack);
        chk("rnd.done", bus.done, e_done);
        chk("rnd.op_sig", bus.op_sig, e_op);
        chk("rnd.busy", bus.busy, e_busy);
        if (e_cur >= 0) chk("rnd.cur_ch", bus.cur_ch, e_cur);
    endtask

    initial begin
        int k, n;
        int gch[3];
        int gstamp[3];

        vt[0] = '{2'b01,  10,   3,  0, 0,   3,  10,  30,  30,  31};
        vt[1] = '{2'b01,   0,   5,  0, 0,   0,  -1,  -1,   0,   0};
        vt[2] = '{2'b01,   5,  10, 12, 0,   2,   5,  10,  -1,  13};
        vt[3] = '{2'b01,   1,   4,  0, 0,   4,   1,   4,   4,   5};
        vt[4] = '{2'b10,   3,   0,  0, 1,   0,  -1,  -1,   0,   0};
        vt[5] = '{2'b11,   2,   3,  0, 0,   3,   2,   6,   6,   7};
        vt[6] = '{2'b11,   3,   2,  6, 1,   2,   3,   6,   6,   7};
        vt[7] = '{2'b01, 255,   1,  0, 0,   1, 255, 255, 255, 256};
        vt[8] = '{2'b10,   1, 255,  0, 1, 255,   1, 255, 255, 256};

        rst = 1'b1;
        bus.req = '0;
        bus.period = '0;
        bus.count = '0;
        bus.abort = 1'b0;
        #12;
        chk("reset.ack", bus.ack, 0);
        chk("reset.done", bus.done, 0);
        chk("reset.op_sig", bus.op_sig, 0);
        chk("reset.busy", bus.busy, 0);
        chk("reset.cur_ch", bus.cur_ch, 0);
        do_reset();

        for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

        // Both channels held requesting: alternating grants, one idle cycle between trains.
        do_reset();
        set_cfg(0, 4, 2);
        set_cfg(1, 4, 2);
        bus.req = 2'b11;
        k = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (bus.ack != '0 && k < 3) begin
                gch[k] = bus.ack[1] ? 1 : 0;
                gstamp[k] = cyc;
                k++;
            end
        end
        bus.req = '0;
        chk("rr.grants", k, 3);
        if (k == 3) begin
            chk("rr.ch0", gch[0], 0);
            chk("rr.ch1", gch[1], 1);
            chk("rr.ch2", gch[2], 0);
            chk("rr.gap01", gstamp[1] - gstamp[0], 10);
            chk("rr.gap12", gstamp[2] - gstamp[1], 10);
        end
        repeat (15) @(negedge clk);

        // Asynchronous reset in the middle of a train.
        do_reset();
        set_cfg(0, 5, 4);
        bus.req = 2'b01;
        n = 0;
        @(negedge clk);
        while (bus.ack == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mrst.ack0", bus.ack, 2'b01);
        bus.req = '0;
        repeat (7) @(negedge clk);
        chk("mrst.busy_before", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mrst.ack", bus.ack, 0);
        chk("mrst.done", bus.done, 0);
        chk("mrst.op_sig", bus.op_sig, 0);
        chk("mrst.busy", bus.busy, 0);
        chk("mrst.cur_ch", bus.cur_ch, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 2'b10;
        n = 0;
        @(negedge clk);
        while (bus.ack == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mrst.ack1", bus.ack, 2'b10);
        chk("mrst.cur_ch1", bus.cur_ch, 1);
        bus.req = '0;
        repeat (30) @(negedge clk);

        // Random traffic checked cycle by cycle against the train model.
        do_reset();
        m_run = 0; m_last = N_CH - 1; m_cyc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            model_step();
            for (int ch = 0; ch < int'(N_CH); ch++) begin
                if (bus.ack[ch]) begin
                    bus.req[ch] = 1'b0;
                end else if (!bus.req[ch] && $urandom_range(0, 3) == 0) begin
                    set_cfg(ch, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
                    bus.req[ch] = 1'b1;
                end
            end
            bus.abort = ($urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pulse_train_sched.md
PULSE_TRAIN_SCHED -- requirements
Module: pulse_train_sched

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of requesting channels.
REQ-002 SHALL have parameter PW, default 8: period field width in bits.
REQ-003 SHALL have parameter CW, default 8: pulse-count field width in bits.
REQ-004 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  N_CH: per-channel level request; held until ack.
REQ-007 SHALL have port period  input  N_CH*PW: per-channel period; channel i occupies bits [i*PW +: PW].
REQ-008 SHALL have port count  input  N_CH*CW: per-channel pulse count; channel i occupies bits [i*CW +: CW].
REQ-009 SHALL have port abort  input  1: terminates the active train.
REQ-010 SHALL have port ack  output  N_CH: one-cycle pulse; request accepted and config latched.
REQ-011 SHALL have port done  output  N_CH: one-cycle pulse; train completed normally.
REQ-012 SHALL have port op_sig  output  1: shared pulse output, one-cycle high per period.
REQ-013 SHALL have port busy  output  1: high while a train is running.
REQ-014 SHALL have port cur_ch  output  $clog2(N_CH): index of the granted channel, valid while busy.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; all outputs SHALL be registered.
REQ-016 In IDLE with any req bit set, the block SHALL grant one channel round-robin, searching upward from last_served+1 with wrap-around.
REQ-017 On grant, the block SHALL latch that channel's period P and count C, pulse ack[ch] for one cycle, set cur_ch, and, if P!=0 and C!=0, enter RUN with busy=1 in the same cycle as ack.
REQ-018 If the latched P==0 or C==0, the block SHALL pulse ack[ch] and done[ch] in the same cycle, emit no op_sig, and remain in IDLE.
REQ-019 In RUN, op_sig SHALL be high exactly on cycles ack+P, ack+2P, ..., ack+C*P, and low on all other cycles.
REQ-020 P==1 SHALL give op_sig high on C consecutive cycles.
REQ-021 done[ch] SHALL be high in the same cycle as the C-th op_sig; the next cycle SHALL be IDLE with busy=0 and last_served=ch.
REQ-022 A new grant SHALL NOT occur earlier than one cycle after leaving RUN; back-to-back trains are separated by exactly one IDLE cycle.
REQ-023 req changes during RUN SHALL be ignored until IDLE; a req dropped before ack SHALL be lost silently.
REQ-024 abort sampled high in RUN SHALL return the FSM to IDLE on the next edge, with op_sig=0 and busy=0 from that cycle on, no done pulse, and last_served updated to the aborted channel.
REQ-025 If abort coincides with the cycle of the final op_sig, that op_sig and done SHALL still be output, since both are registered from the prior state.
REQ-026 abort in IDLE SHALL have no effect.
REQ-027 The internal period counter SHALL be PW bits wide and the pulse counter CW bits wide, and neither SHALL overflow at maximum values (P=2^PW-1, C=2^CW-1).

Reset
REQ-028 rst high SHALL immediately force IDLE, ack=0, done=0, op_sig=0, busy=0, cur_ch=0, all counters to 0, and last_served to N_CH-1, so that channel 0 wins first.
REQ-029 rst asserted mid-train SHALL drop the train with no done pulse; after release, the block SHALL arbitrate from IDLE.

Structure
REQ-030 Package pulse_sched_pkg SHALL hold the state enum (IDLE, RUN) and the default N_CH, PW and CW constants.
REQ-031 The period counter and pulse strobe SHALL be one sub-module, period_pulse_gen, with load, enable, period in, and pulse out; the arbiter and FSM SHALL stay in the top level.

Verification
REQ-032 Reset then req=01, P0=10, C0=3 -> ack[0] at cycle t, op_sig at t+10, t+20, t+30, done[0] at t+30, busy low at t+31.
REQ-033 req=11 held, P=4, C=2 for both channels -> grant order ch0, ch1, ch0, with one IDLE cycle between trains.
REQ-034 req=01, P0=0 (C0=5) -> ack[0] and done[0] in the same cycle, no op_sig, busy stays 0.
REQ-035 P0=5, C0=10, abort pulsed at ack+12 -> op_sig seen at +5 and +10 only, busy low from +13, no done[0].
REQ-036 rst asserted at ack+7 of a P=5, C=4 train -> all outputs 0 immediately; after release with req=10, ch1 is granted.
REQ-037 P0=1, C0=4 -> op_sig high on 4 consecutive cycles after ack, done[0] on the 4th.
